// File: rtl/exec_cc_unit_pkg.sv
// Shared condition-code definitions for the execute stage and the fetch-stage predictor checker.
package exec_cc_unit_pkg;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam int ZF_BIT = 2;
  localparam int SF_BIT = 1;
  localparam int OF_BIT = 0;

  localparam logic [2:0] CC_RESET_DEFAULT = 3'b100;

endpackage

// File: rtl/exec_cc_unit_cond_eval.sv
// Purely combinational Y86 jXX/cmovXX condition evaluation from {ZF,SF,OF} and ifun.
module cond_eval
  import exec_cc_unit_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf;
  logic lt;

  assign zf = flags[ZF_BIT];
  assign lt = flags[SF_BIT] ^ flags[OF_BIT];

  // Codes 7-15 are not defined conditions and never fire.
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_unit.sv
// Execute-stage CC register, condition evaluation and E->M pipeline register.
// Optional taken-branch counter enabled by defining EXEC_CC_TAKEN_CNT_EN.
module exec_cc_unit
  import exec_cc_unit_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = CC_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_ovf,
  input  logic             set_cc,
  input  logic             cc_inhibit,
  input  logic [3:0]       ifun,
  input  logic             e_valid,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic [2:0]       cc_flags,
  output logic             e_cnd,
  output logic [WIDTH-1:0] m_valE,
  output logic             m_cnd,
  output logic             m_valid
`ifdef EXEC_CC_TAKEN_CNT_EN
 ,output logic [31:0]      taken_cnt
`endif
);

  logic [2:0] flags_n;
  logic       cc_we;
  logic       m_load;

  always_comb begin
    flags_n         = '0;
    flags_n[ZF_BIT] = (alu_res == '0);
    flags_n[SF_BIT] = alu_res[WIDTH-1];
    flags_n[OF_BIT] = alu_ovf;
  end

  assign cc_we  = set_cc & ~cc_inhibit & e_valid;
  assign m_load = ~m_stall & ~m_bubble;

  // Evaluated against the registered flags so alu_res never reaches e_cnd.
  cond_eval u_cond_eval (
    .flags (cc_flags),
    .ifun  (ifun),
    .cnd   (e_cnd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_flags <= CC_RESET;
      m_valE   <= '0;
      m_cnd    <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      if (cc_we) begin
        cc_flags <= flags_n;
      end
      // Stall has priority over bubble.
      if (!m_stall) begin
        if (m_bubble) begin
          m_valE  <= '0;
          m_cnd   <= 1'b0;
          m_valid <= 1'b0;
        end else begin
          m_valE  <= alu_res;
          m_cnd   <= e_cnd;
          m_valid <= e_valid;
        end
      end
    end
  end

`ifdef EXEC_CC_TAKEN_CNT_EN
  // Counts real conditional transfers; unconditional (ifun 0) does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (m_load && e_valid && e_cnd && (ifun != C_YES)) begin
      taken_cnt <= taken_cnt + 32'd1;
    end
  end
`else
  logic unused_load;
  assign unused_load = m_load;
`endif

endmodule
